// File: rtl/throttle_rate_ctrl.sv
// Throttle rate-step controller: button presses move a saturating target level, and
// the live level ramps toward it one divider handshake (plus dwell) at a time.
module throttle_rate_ctrl #(
  parameter int DIV_W        = 25,
  parameter int NUM_LEVELS   = 6,
  parameter int DWELL_CYCLES = 1000000,
  parameter int ACK_TIMEOUT  = 2000000
) (
  input  logic             CLK_50,
  input  logic             reset_n,
  input  logic             up_req,
  input  logic             dn_req,
  input  logic             cfg_ack,
  output logic [DIV_W-1:0] div_half,
  output logic             cfg_valid,
  output logic [2:0]       level,
  output logic [2:0]       target,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DWELL    = 2'd2
  } state_e;

  localparam logic [2:0]  TOP_LVL    = 3'(NUM_LEVELS - 1);
  localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT) - 32'd1;
  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES) - 32'd1;

  function automatic logic [DIV_W-1:0] div_lookup(input logic [2:0] idx);
    logic [DIV_W-1:0] r;
    case (idx)
      3'd0:    r = DIV_W'(32'd25000000);
      3'd1:    r = DIV_W'(32'd12500000);
      3'd2:    r = DIV_W'(32'd8333333);
      3'd3:    r = DIV_W'(32'd6250000);
      3'd4:    r = DIV_W'(32'd5000000);
      3'd5:    r = DIV_W'(32'd4166667);
      default: r = DIV_W'(32'd25000000);
    endcase
    return r;
  endfunction

  state_e           state_q;
  logic             up_hist_q, dn_hist_q;
  logic [2:0]       target_q, target_d;
  logic [2:0]       level_q, nxt_q, step_lvl;
  logic [DIV_W-1:0] div_q;
  logic             valid_q, busy_q, err_q;
  logic [31:0]      cnt_q;
  logic             up_press, dn_press;

  // Rising-edge press detection and saturating target update
  always_comb begin
    up_press = up_req & ~up_hist_q;
    dn_press = dn_req & ~dn_hist_q;
    target_d = target_q;
    if (up_press && !dn_press) begin
      if (target_q < TOP_LVL) target_d = target_q + 3'd1;
      else                    target_d = target_q;
    end else if (dn_press && !up_press) begin
      if (target_q != 3'd0) target_d = target_q - 3'd1;
      else                  target_d = target_q;
    end else begin
      target_d = target_q;
    end
  end

  // One level toward the target; only consumed when level differs from target
  always_comb begin
    if (target_q > level_q) step_lvl = level_q + 3'd1;
    else                    step_lvl = level_q - 3'd1;
  end

  // Button history resets high so a button held through reset is not a press
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      up_hist_q <= 1'b1;
      dn_hist_q <= 1'b1;
      target_q  <= 3'd0;
    end else begin
      up_hist_q <= up_req;
      dn_hist_q <= dn_req;
      target_q  <= target_d;
    end
  end

  // Step sequencer: issue step, wait for ack or timeout, then dwell
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      level_q <= 3'd0;
      nxt_q   <= 3'd0;
      div_q   <= div_lookup(3'd0);
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (level_q != target_q) begin
            nxt_q   <= step_lvl;
            div_q   <= div_lookup(step_lvl);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= 32'd0;
            state_q <= ST_WAIT_ACK;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_WAIT_ACK: begin
          // Ack takes priority over a timeout landing on the same edge
          if (cfg_ack) begin
            level_q <= nxt_q;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
            state_q <= ST_DWELL;
          end else if (cnt_q == ACK_LAST) begin
            valid_q <= 1'b0;
            div_q   <= div_lookup(level_q);
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_DWELL: begin
          if (cnt_q == DWELL_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign div_half  = div_q;
  assign cfg_valid = valid_q;
  assign level     = level_q;
  assign target    = target_q;
  assign busy      = busy_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_throttle_rate_ctrl.sv
// Bench for throttle_rate_ctrl: vector table for press handling, a divider model that
// acks two cycles after valid, and a queue of expected div_half values per handshake.
module tb_throttle_rate_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        up_req = 1'b0, dn_req = 1'b0, cfg_ack = 1'b0;
  logic [24:0] div_half;
  logic        cfg_valid, busy, cfg_err;
  logic [2:0]  level, target;

  throttle_rate_ctrl #(.DIV_W(25), .NUM_LEVELS(6), .DWELL_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .CLK_50(clk), .reset_n(reset_n), .up_req(up_req), .dn_req(dn_req), .cfg_ack(cfg_ack),
    .div_half(div_half), .cfg_valid(cfg_valid), .level(level), .target(target),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       up;
    logic       dn;
    logic [2:0] exp_t;
  } vec_t;

  vec_t        vecs[26];
  logic [24:0] tbl[6];
  logic [24:0] exp_q[$];
  int          n_pass = 0, n_total = 0;
  int          hs_cnt = 0, err_cnt = 0, age = 0, vcount = 0, hs0 = 0;
  logic        ack_en = 1'b1, last_hs = 1'b0, valid_seen = 1'b0;
  logic [2:0]  exp_tgt = 3'd0;

  function automatic void check(string name, longint got, longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endfunction

  task automatic tick();
    logic        hs;
    logic [24:0] d;
    logic [24:0] e;
    hs = cfg_valid && cfg_ack;
    d  = div_half;
    @(posedge clk);
    #1;
    last_hs = hs;
    if (hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL hs_unexpected: got handshake with div %0d, expected none", d);
      end else begin
        e = exp_q.pop_front();
        check("hs_div", d, e);
      end
    end
    if (cfg_valid) valid_seen = 1'b1;
    if (cfg_err) err_cnt++;
    if (cfg_valid && ack_en) begin
      age++;
      cfg_ack = (age >= 2);
    end else begin
      age = 0;
      cfg_ack = 1'b0;
    end
  endtask

  task automatic wait_hs(input string name, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (last_hs) break;
    end
    check(name, (i < bound), 1);
  endtask

  task automatic settle(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (level == target && !busy && !cfg_valid) break;
      tick();
    end
    check(name, (i < 300), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    up_req = 1'b0; dn_req = 1'b0; cfg_ack = 1'b0; age = 0;
    tick();
    reset_n = 1'b1;
    tick();
    exp_tgt = 3'd0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      up_req = vecs[i].up;
      dn_req = vecs[i].dn;
      if (vecs[i].exp_t != exp_tgt) begin
        exp_q.push_back(tbl[vecs[i].exp_t]);
        exp_tgt = vecs[i].exp_t;
      end
      tick();
      check("vec_target", target, vecs[i].exp_t);
    end
    up_req = 1'b0;
    dn_req = 1'b0;
  endtask

  initial begin
    tbl = '{25'd25000000, 25'd12500000, 25'd8333333, 25'd6250000, 25'd5000000, 25'd4166667};
    vecs[0]  = '{1'b1, 1'b0, 3'd1}; vecs[1]  = '{1'b0, 1'b0, 3'd1};
    vecs[2]  = '{1'b1, 1'b0, 3'd2}; vecs[3]  = '{1'b0, 1'b0, 3'd2};
    vecs[4]  = '{1'b1, 1'b0, 3'd3}; vecs[5]  = '{1'b0, 1'b0, 3'd3};
    vecs[6]  = '{1'b1, 1'b0, 3'd4}; vecs[7]  = '{1'b0, 1'b0, 3'd4};
    vecs[8]  = '{1'b1, 1'b0, 3'd5}; vecs[9]  = '{1'b0, 1'b0, 3'd5};
    vecs[10] = '{1'b1, 1'b0, 3'd5}; vecs[11] = '{1'b0, 1'b0, 3'd5};
    vecs[12] = '{1'b1, 1'b0, 3'd5}; vecs[13] = '{1'b0, 1'b0, 3'd5};
    vecs[14] = '{1'b0, 1'b1, 3'd4}; vecs[15] = '{1'b0, 1'b0, 3'd4};
    vecs[16] = '{1'b0, 1'b1, 3'd3}; vecs[17] = '{1'b0, 1'b0, 3'd3};
    vecs[18] = '{1'b0, 1'b1, 3'd2}; vecs[19] = '{1'b0, 1'b0, 3'd2};
    vecs[20] = '{1'b0, 1'b1, 3'd1}; vecs[21] = '{1'b0, 1'b0, 3'd1};
    vecs[22] = '{1'b0, 1'b1, 3'd0}; vecs[23] = '{1'b0, 1'b0, 3'd0};
    vecs[24] = '{1'b0, 1'b1, 3'd0}; vecs[25] = '{1'b0, 1'b0, 3'd0};

    // Reset with up held through release
    up_req = 1'b1;
    tick(); tick();
    check("rst_level", level, 0);
    check("rst_target", target, 0);
    check("rst_div", div_half, 25000000);
    check("rst_valid", cfg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cfg_err, 0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("held_target", target, 0);
    check("held_valid", cfg_valid, 0);
    check("held_div", div_half, 25000000);
    up_req = 1'b0;
    tick();

    // Single up step and its latency
    up_req = 1'b1;
    exp_q.push_back(tbl[1]);
    tick();
    check("up1_target", target, 1);
    check("up1_valid_not_yet", cfg_valid, 0);
    up_req = 1'b0;
    tick();
    check("up1_valid", cfg_valid, 1);
    check("up1_div", div_half, 12500000);
    check("up1_busy", busy, 1);
    tick(); tick();
    check("up1_hs", last_hs, 1);
    check("up1_level", level, 1);
    check("up1_valid_drop", cfg_valid, 0);
    tick(); tick(); tick();
    check("dwell_busy", busy, 1);
    tick();
    check("dwell_done", busy, 0);

    // Full ramp up with saturation, then back down to 2
    do_reset();
    hs0 = hs_cnt;
    run_vecs(0, 13);
    settle("ramp_up_settle");
    check("ramp_up_level", level, 5);
    check("ramp_up_hs", hs_cnt - hs0, 5);
    check("ramp_up_q", exp_q.size(), 0);
    exp_tgt = 3'd5;
    run_vecs(14, 19);
    settle("ramp_dn_settle");
    check("ramp_dn_level", level, 2);

    // Simultaneous presses are ignored
    hs0 = hs_cnt;
    valid_seen = 1'b0;
    up_req = 1'b1; dn_req = 1'b1;
    tick();
    check("both_target", target, 2);
    up_req = 1'b0; dn_req = 1'b0;
    repeat (8) tick();
    check("both_no_valid", valid_seen, 0);
    check("both_no_hs", hs_cnt - hs0, 0);

    // Down saturation at zero
    exp_tgt = 3'd2;
    run_vecs(20, 25);
    settle("sat_settle");
    check("sat_level", level, 0);
    check("sat_q", exp_q.size(), 0);

    // Ack timeout and retry
    ack_en = 1'b0;
    err_cnt = 0;
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    tick();
    check("to_valid", cfg_valid, 1);
    vcount = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_valid) vcount++;
      else break;
    end
    check("to_valid_cycles", vcount, 8);
    check("to_err", cfg_err, 1);
    check("to_level", level, 0);
    check("to_div_revert", div_half, 25000000);
    tick();
    check("to_err_pulse", cfg_err, 0);
    check("to_retry_valid", cfg_valid, 1);
    check("to_retry_div", div_half, 12500000);
    check("to_err_count", err_cnt, 1);
    exp_q.push_back(tbl[1]);
    ack_en = 1'b1;
    wait_hs("to_retry_hs", 20);
    check("to_retry_level", level, 1);
    settle("to_settle");

    // Reset in the middle of a handshake
    ack_en = 1'b0;
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    tick(); tick(); tick();
    check("mid_valid", cfg_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_target", target, 0);
    check("mid_rst_div", div_half, 25000000);
    check("mid_rst_valid", cfg_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", cfg_err, 0);
    #5;
    reset_n = 1'b1;
    valid_seen = 1'b0;
    repeat (12) tick();
    check("post_rst_no_valid", valid_seen, 0);
    check("post_rst_target", target, 0);
    check("post_rst_level", level, 0);
    check("final_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
